cic_decimator: RTL and testbench

- Multi-stage CIC decimation filter. Reduces the high-rate demodulated baseband stream to the audio rate.
- Directly upstream of the PWM audio output stage. Its out_valid/out_data drive that stage's data_valid/data inputs.
- Output is signed two's complement and OUT_WIDTH wide. It is gain-normalised so that a DC input reproduces the same value at the output.

---
 rtl/cic_pkg.sv | 10 +
 rtl/cic_comb_stage.sv | 31 +++
 rtl/cic_decimator.sv | 116 +++++++++++
 tb/tb_cic_decimator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg: legal parameter bounds and accumulator width helper for the CIC decimator.
package cic_pkg;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 5;
  localparam int DECIM_LOG2_MIN = 1;
  localparam int DECIM_LOG2_MAX = 12;
  function automatic int reg_width(input int in_width, input int stages, input int decim_log2);
    return in_width + stages * decim_log2;
  endfunction
endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one M=1 comb register stage, advancing only on its incoming strobe.
module cic_comb_stage import cic_pkg::*; #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_strobe,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         out_strobe
);
  logic [W-1:0] d_q, d_d, y_q, y_d;
  logic strobe_q;
  always_comb begin
    d_d = in_strobe ? x : d_q;
    y_d = in_strobe ? x - d_q : y_q;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      d_q <= '0;
      y_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      d_q <= d_d;
      y_q <= y_d;
      strobe_q <= in_strobe;
    end
  end
  assign y = y_q;
  assign out_strobe = strobe_q;
endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: STAGES-order CIC decimator by 2**DECIM_LOG2, gain-normalised output.
// Optional CIC_ROUND_SAT_EN: round-half-up plus saturation with one extra pipeline stage.
module cic_decimator import cic_pkg::*; #(
  parameter int IN_WIDTH   = 12,
  parameter int OUT_WIDTH  = 12,
  parameter int STAGES     = 3,
  parameter int DECIM_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data
);
  localparam int REG_WIDTH = reg_width(IN_WIDTH, STAGES, DECIM_LOG2);
  typedef logic signed [REG_WIDTH-1:0] acc_t;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || DECIM_LOG2 < DECIM_LOG2_MIN ||
      DECIM_LOG2 > DECIM_LOG2_MAX || OUT_WIDTH > REG_WIDTH) begin : g_bad_params
    $error("cic_decimator: illegal parameter set");
  end

  acc_t integ_q [STAGES];
  acc_t integ_d [STAGES];
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  acc_t cap_q, cap_d;
  logic cap_v_q, capture;
  logic [REG_WIDTH-1:0] x_w [STAGES+1];
  logic s_w [STAGES+1];
  logic out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

  // Integrators wrap modulo 2**REG_WIDTH; the combs undo the wrap exactly.
  always_comb begin
    for (int k = 0; k < STAGES; k++) integ_d[k] = integ_q[k];
    if (in_valid) begin
      integ_d[0] = integ_q[0] + acc_t'($signed(in_data));
      for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
    capture = in_valid && (cnt_q == '1);
    cnt_d = in_valid ? cnt_q + 1'b1 : cnt_q;
    cap_d = capture ? integ_q[STAGES-1] : cap_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
      cnt_q <= '0;
      cap_q <= '0;
      cap_v_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= integ_d[k];
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      cap_v_q <= capture;
    end
  end

  assign x_w[0] = cap_q;
  assign s_w[0] = cap_v_q;
  for (genvar i = 0; i < STAGES; i++) begin : g_comb
    cic_comb_stage #(.W(REG_WIDTH)) u_comb (
      .clk       (clk),
      .arst_n    (arst_n),
      .in_strobe (s_w[i]),
      .x         (x_w[i]),
      .y         (x_w[i+1]),
      .out_strobe(s_w[i+1])
    );
  end

`ifdef CIC_ROUND_SAT_EN
  localparam int SH = REG_WIDTH - OUT_WIDTH;
  localparam logic signed [REG_WIDTH:0] HALF =
    (SH == 0) ? '0 : ((REG_WIDTH+1)'(1) << ((SH == 0) ? 0 : SH - 1));
  localparam logic signed [REG_WIDTH:0] MAXV = {{(SH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [REG_WIDTH:0] MINV = ~MAXV;
  logic signed [REG_WIDTH:0] rnd_q, rnd_d, sh;
  logic rnd_v_q;
  always_comb begin
    rnd_d = s_w[STAGES] ? $signed({x_w[STAGES][REG_WIDTH-1], x_w[STAGES]}) + HALF : rnd_q;
    sh = rnd_q >>> SH;
    out_valid_d = rnd_v_q;
    out_data_d = !rnd_v_q ? out_data_q :
                 (sh > MAXV) ? MAXV[OUT_WIDTH-1:0] :
                 (sh < MINV) ? MINV[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rnd_q <= '0;
      rnd_v_q <= 1'b0;
    end else begin
      rnd_q <= rnd_d;
      rnd_v_q <= s_w[STAGES];
    end
  end
`else
  always_comb begin
    out_valid_d = s_w[STAGES];
    out_data_d = s_w[STAGES] ? x_w[STAGES][REG_WIDTH-1 -: OUT_WIDTH] : out_data_q;
  end
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: scoreboard bench for cic_decimator at default parameters.
module tb_cic_decimator;
`ifdef CIC_ROUND_SAT_EN
  localparam int LAT = 5;
  localparam int ALT_LO = 0;
`else
  localparam int LAT = 4;
  localparam int ALT_LO = -1;
`endif
  typedef struct {
    int cyc;
    bit chk;
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];
  logic clk = 0, arst_n = 1, in_valid = 0;
  logic [11:0] in_data = '0;
  logic out_valid;
  logic [11:0] out_data;
  int checks = 0, failures = 0, cyc = 0, vcnt = 0, ncap = 0, nout = 0;
  int exp_lo = 0, exp_hi = 0;

  cic_decimator dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // Every output strobe must match the oldest pending capture in time and value range.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (arst_n && out_valid) begin
      nout++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid cyc=%0d data=%0d required=no_strobe", cyc, $signed(out_data));
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc) begin
          failures++;
          $display("FAIL strobe_time got cyc=%0d required cyc=%0d", cyc, e.cyc);
        end
        if (e.chk) begin
          checks++;
          if (int'($signed(out_data)) < e.lo || int'($signed(out_data)) > e.hi) begin
            failures++;
            $display("FAIL out_data got=%0d required=[%0d,%0d]", $signed(out_data), e.lo, e.hi);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic signed [11:0] d);
    int c;
    @(negedge clk);
    in_valid = v;
    in_data = d;
    c = cyc;
    @(posedge clk);
    if (v) begin
      if (vcnt == 15) begin
        ncap++;
        sb.push_back('{c + 1 + LAT, ncap > 3, exp_lo, exp_hi});
      end
      vcnt = (vcnt + 1) % 16;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 0;
    in_valid = 0;
    sb.delete();
    vcnt = 0;
    ncap = 0;
    nout = 0;
    repeat (2) @(negedge clk);
    arst_n = 1;
  endtask

  task automatic test_reset();
    #2 arst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 12'd0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h required valid=0 data=000", out_valid, out_data);
    end
    repeat (2) @(negedge clk);
    arst_n = 1;
    exp_lo = 100;
    exp_hi = 100;
    for (int i = 0; i < 16 * 2; i++) drive(1, 12'sd100);
    repeat (8) drive(0, 0);
    checks++;
    if (sb.size() != 0 || nout != ncap) begin
      failures++;
      $display("FAIL reset_first_out got outputs=%0d pending=%0d required outputs=%0d pending=0", nout, sb.size(), ncap);
    end
  endtask

  task automatic test_dc(input logic signed [11:0] d, input int nouts);
    do_reset();
    exp_lo = int'(d);
    exp_hi = int'(d);
    for (int i = 0; i < 16 * nouts; i++) drive(1, d);
    repeat (8) drive(0, 0);
    checks++;
    if (sb.size() != 0 || nout != nouts) begin
      failures++;
      $display("FAIL dc_%0d_count got outputs=%0d pending=%0d required outputs=%0d", d, nout, sb.size(), nouts);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    exp_lo = -37;
    exp_hi = -37;
    for (int i = 0; i < 32 * 7; i++) drive(i % 2 == 0, -12'sd37);
    repeat (8) drive(0, 0);
    checks++;
    if (sb.size() != 0 || nout != 7) begin
      failures++;
      $display("FAIL gapped_count got outputs=%0d pending=%0d required outputs=7", nout, sb.size());
    end
  endtask

  task automatic test_alternating();
    do_reset();
    exp_lo = ALT_LO;
    exp_hi = 0;
    for (int i = 0; i < 16 * 8; i++) drive(1, (i % 2 == 0) ? 12'sd1000 : -12'sd1000);
    repeat (8) drive(0, 0);
    checks++;
    if (sb.size() != 0 || nout != 8) begin
      failures++;
      $display("FAIL alt_count got outputs=%0d pending=%0d required outputs=8", nout, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_lo = 100;
    exp_hi = 100;
    for (int i = 0; i < 16 * 5 + 7; i++) drive(1, 12'sd100);
    @(negedge clk);
    in_valid = 1;
    #3 arst_n = 0;
    sb.delete();
    vcnt = 0;
    ncap = 0;
    nout = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 12'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%b data=%h required valid=0 data=000", out_valid, out_data);
    end
    repeat (3) @(negedge clk);
    arst_n = 1;
    in_valid = 0;
    exp_lo = -500;
    exp_hi = -500;
    for (int i = 0; i < 16 * 5; i++) drive(1, -12'sd500);
    repeat (8) drive(0, 0);
    checks++;
    if (sb.size() != 0 || nout != 5) begin
      failures++;
      $display("FAIL reset_recover got outputs=%0d pending=%0d required outputs=5", nout, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_dc(12'sd100, 8);
    test_dc(-12'sd2048, 20);
    test_dc(12'sd2047, 20);
    test_gapped();
    test_alternating();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
